retire_trace_arbiter: RTL and testbench
=======================================

# retire_trace_arbiter

Shares the single debug write-back trace port between the two retiring pipes, primary and secondary. Each pipe can retire one instruction per cycle; the trace port accepts one record per cycle. The block serialises dual retirement in program order, lane0 before lane1, through a small buffer. It back-pressures both final stages through a shared allowin and sits between the last pipeline stages and the top-level debug_wb_* outputs.

## Interface
- DEPTH, 4, buffer entries; must be ≥2
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- l0_valid_i  in  1  lane0 (primary, older) retire valid
- l0_pc_i  in  32  lane0 PC
- l0_wnum_i  in  5  lane0 destination GPR; 0 = no write
- l0_wdata_i  in  32  lane0 write data
- l1_valid_i, l1_pc_i, l1_wnum_i, l1_wdata_i  in  1/32/5/32  lane1 (secondary, younger), same meaning as lane0
- allowin_o  out  1  both lanes may retire this cycle
- debug_wb_pc  out  32  traced PC (registered)
- debug_wb_rf_wen  out  4  byte write enables (registered)
- debug_wb_rf_wnum  out  5  traced GPR (registered)
- debug_wb_rf_wdata  out  32  traced data (registered)

## Operation
- Record = {pc, wnum, wdata}. Accept: lane valid && allowin_o at posedge.
- Push order per cycle: lane0 record first, then lane1. Only lane1 valid → single push.
- allowin_o = (DEPTH − count) ≥ 2, from the registered count. This is conservative: a same-cycle pop is not credited.
- Pop: each cycle count > 0, head record → output regs; wen = {4{wnum≠0}}.
- Empty cycle: wen = 4'b0; pc/wnum/wdata hold their previous values.
- Push and pop in the same cycle: count' = count + pushes − pop. Count range 0..DEPTH, width clog2(DEPTH+1). Pointers wrap modulo DEPTH.
- Overflow cannot occur while producers obey allowin_o. A push while allowin_o=0 is ignored; the verifier flags it as an assertion failure.
- Records with wnum=0 are still traced: PC advances and wen is 0.

## Timing
- Reset (rst=0 at posedge): count=0, pointers=0; all debug_wb_* outputs = 0; allowin_o=1 from the next cycle.
- Reset mid-operation discards all buffered records.
- Latency, no bypass: record accepted at edge E0 appears on the outputs after edge E1.
- Throughput: one trace record per cycle. Sustained dual retire fills the buffer, then allowin_o toggles.
- Ordering guarantee: the output sequence equals acceptance order, with lane0 before lane1 within a cycle.

## Configuration
- RETIRE_BYPASS_EN defined:
  - When count=0 at E0 and lane0 (or the sole valid lane) is accepted, that record goes directly to the output regs at E0.
  - A lane1 record accepted in the same cycle is pushed into the buffer.
  - Latency for such a record is 0 cycles past acceptance, i.e. visible after E0.
- RETIRE_BYPASS_EN undefined: every record passes through the buffer; latency is 1 cycle past acceptance.
- allowin_o rule is identical in both builds.

## Structure
- Shared package: GPR number width (5) and SINGLE_WORD width (32), plus the retire record struct/typedef {pc, wnum, wdata}.
- Sub-module retire_fifo: 2-write/1-read circular buffer with DEPTH parameter, count output, ordered dual push.
- The top level holds the accept logic, the bypass mux, and the output registers.

## Test plan
- Reset: hold rst=0 for 2 cycles → all debug_wb_* = 0, allowin_o=1; assert reset mid-run with count=3 → count=0, wen=0 next cycle.
- Single write: lane0 pc=0xBFC00000, wnum=3, wdata=0x1234 → pc/wnum/wdata appear with wen=4'hF one cycle after acceptance (same edge with RETIRE_BYPASS_EN). The following cycle has wen=0.
- Dual retire: lane0 {0xBFC00010, r4, 0xA}, lane1 {0xBFC00014, r5, 0xB} in one cycle → trace shows r4 then r5 on consecutive cycles.
- Backpressure, DEPTH=4:
  - Dual retire every cycle while allowed → allowin_o falls when count reaches 3.
  - The pipeline holds; no record is lost or reordered across 20 random records checked against a scoreboard.
- No-write record: lane0 wnum=0, pc=0xBFC00020 → pc traced, wen=4'b0000.
- Lane1-only: l1_valid=1, l0_valid=0, wnum=7 → single record traced; count returns to 0.

Source files
------------

// File: rtl/retire_trace_arbiter_pkg.sv
// Shared types for the retire trace arbiter: GPR / word widths and the
// retire record that moves from the retiring pipes to the debug trace port.
package retire_trace_arbiter_pkg;

    localparam int GPR_W       = 5;
    localparam int SINGLE_WORD = 32;

    // One retired instruction as seen by the trace port.
    typedef struct packed {
        logic [SINGLE_WORD-1:0] pc;
        logic [GPR_W-1:0]       wnum;
        logic [SINGLE_WORD-1:0] wdata;
    } retire_rec_t;

    // Register 0 is never written, so a record targeting it traces with no byte enables.
    function automatic logic [3:0] wb_wen(input logic [GPR_W-1:0] wnum);
        return {4{wnum != '0}};
    endfunction

endpackage

// File: rtl/retire_trace_arbiter_fifo.sv
// retire_fifo: 2-write / 1-read circular buffer of retire records.
// Port 0 is always the older record; when only port 1 pushes, it takes the
// slot port 0 would have used, so program order is kept in the buffer.
module retire_fifo
    import retire_trace_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push0_i,
    input  retire_rec_t                  rec0_i,
    input  logic                         push1_i,
    input  retire_rec_t                  rec1_i,
    input  logic                         pop_i,
    output retire_rec_t                  head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    retire_rec_t   mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wptr_p1;
    logic          wr_a, wr_b, do_pop;
    retire_rec_t   wa_rec;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Map the two push ports onto one or two consecutive slots and compute next pointers/count.
    always_comb begin
        wr_a    = push0_i | push1_i;
        wr_b    = push0_i & push1_i;
        wa_rec  = push0_i ? rec0_i : rec1_i;
        do_pop  = pop_i && (count_q != '0);
        wptr_p1 = ptr_inc(wptr_q);
        wptr_d  = wptr_q;
        if (wr_b) begin
            wptr_d = ptr_inc(wptr_p1);
        end else if (wr_a) begin
            wptr_d = wptr_p1;
        end
        rptr_d  = do_pop ? ptr_inc(rptr_q) : rptr_q;
        count_d = count_q + CW'(wr_a) + CW'(wr_b) - CW'(do_pop);
    end

    // Pointer and occupancy state; reset empties the buffer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (rst && wr_a) begin
            mem_q[wptr_q] <= wa_rec;
        end
        if (rst && wr_b) begin
            mem_q[wptr_p1] <= rec1_i;
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;

    // The upstream allowin is conservative, so pushes never exceed free space.
    overflow_chk: assert property (@(posedge clk) disable iff (!rst)
        (int'(count_q) + int'(wr_a) + int'(wr_b)) <= DEPTH);

endmodule

// File: rtl/retire_trace_arbiter.sv
// retire_trace_arbiter: serialises dual retirement (lane0 older, lane1
// younger) onto the single debug write-back trace port through a small
// buffer, back-pressuring both retire stages via a shared allowin.
// Optional macro RETIRE_BYPASS_EN: when the buffer is empty, the oldest
// accepted record goes straight to the trace registers in the same cycle.
module retire_trace_arbiter
    import retire_trace_arbiter_pkg::*;
#(
    parameter int DEPTH = 4  // buffer entries, at least 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   l0_valid_i,
    input  logic [SINGLE_WORD-1:0] l0_pc_i,
    input  logic [GPR_W-1:0]       l0_wnum_i,
    input  logic [SINGLE_WORD-1:0] l0_wdata_i,
    input  logic                   l1_valid_i,
    input  logic [SINGLE_WORD-1:0] l1_pc_i,
    input  logic [GPR_W-1:0]       l1_wnum_i,
    input  logic [SINGLE_WORD-1:0] l1_wdata_i,
    output logic                   allowin_o,
    output logic [SINGLE_WORD-1:0] debug_wb_pc,
    output logic [3:0]             debug_wb_rf_wen,
    output logic [GPR_W-1:0]       debug_wb_rf_wnum,
    output logic [SINGLE_WORD-1:0] debug_wb_rf_wdata
);

    localparam int CW = $clog2(DEPTH + 1);

    retire_rec_t            rec0, rec1, head, out_rec_d;
    logic [CW-1:0]          count;
    logic                   acc0, acc1, push0, push1, pop, byp, load_d;
    logic [SINGLE_WORD-1:0] wb_pc_q;
    logic [3:0]             wb_wen_q;
    logic [GPR_W-1:0]       wb_wnum_q;
    logic [SINGLE_WORD-1:0] wb_wdata_q;

    assign rec0 = '{pc: l0_pc_i, wnum: l0_wnum_i, wdata: l0_wdata_i};
    assign rec1 = '{pc: l1_pc_i, wnum: l1_wnum_i, wdata: l1_wdata_i};

    // Room for a full dual retire is required from the registered count; a
    // same-cycle pop is deliberately not credited to keep this off the pop path.
    assign allowin_o = (DEPTH - int'(count)) >= 2;
    assign acc0      = l0_valid_i && allowin_o;
    assign acc1      = l1_valid_i && allowin_o;
    assign pop       = (count != '0);

`ifdef RETIRE_BYPASS_EN
    // With nothing buffered, the oldest accepted record skips the buffer.
    assign byp = (count == '0) && (acc0 || acc1);
`else
    assign byp = 1'b0;
`endif

    // The bypassed record (if any) is the oldest, so only the younger one is pushed.
    assign push0 = acc0 && !byp;
    assign push1 = acc1 && !(byp && !acc0);

    retire_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push0_i (push0),
        .rec0_i  (rec0),
        .push1_i (push1),
        .rec1_i  (rec1),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (count)
    );

    // Pick what the trace registers load: buffer head first, else a bypassed record.
    always_comb begin
        load_d    = 1'b0;
        out_rec_d = head;
        if (pop) begin
            load_d    = 1'b1;
            out_rec_d = head;
        end else if (byp) begin
            load_d    = 1'b1;
            out_rec_d = acc0 ? rec0 : rec1;
        end
    end

    // Trace registers: new record loads everything, idle cycles drop wen and hold the rest.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_pc_q    <= '0;
            wb_wen_q   <= '0;
            wb_wnum_q  <= '0;
            wb_wdata_q <= '0;
        end else if (load_d) begin
            wb_pc_q    <= out_rec_d.pc;
            wb_wen_q   <= wb_wen(out_rec_d.wnum);
            wb_wnum_q  <= out_rec_d.wnum;
            wb_wdata_q <= out_rec_d.wdata;
        end else begin
            wb_wen_q   <= '0;
        end
    end

    assign debug_wb_pc       = wb_pc_q;
    assign debug_wb_rf_wen   = wb_wen_q;
    assign debug_wb_rf_wnum  = wb_wnum_q;
    assign debug_wb_rf_wdata = wb_wdata_q;

endmodule

// File: tb/tb_retire_trace_arbiter.sv
// Scoreboard bench for retire_trace_arbiter. The reference model works at the
// level of records: each accepted record is due on the trace port at edge
// max(accept_edge + LAT, previous_due + 1), and the buffer occupancy seen by
// allowin is the number of earlier records not yet due.
`timescale 1ns/1ps
module tb_retire_trace_arbiter;

    localparam int DEPTH = 4;
`ifdef RETIRE_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        l0_valid_i = 1'b0, l1_valid_i = 1'b0;
    logic [31:0] l0_pc_i = '0, l0_wdata_i = '0, l1_pc_i = '0, l1_wdata_i = '0;
    logic [4:0]  l0_wnum_i = '0, l1_wnum_i = '0;
    logic        allowin_o;
    logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;

    retire_trace_arbiter #(.DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .l0_valid_i        (l0_valid_i),
        .l0_pc_i           (l0_pc_i),
        .l0_wnum_i         (l0_wnum_i),
        .l0_wdata_i        (l0_wdata_i),
        .l1_valid_i        (l1_valid_i),
        .l1_pc_i           (l1_pc_i),
        .l1_wnum_i         (l1_wnum_i),
        .l1_wdata_i        (l1_wdata_i),
        .allowin_o         (allowin_o),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          last_due = -100;
    int          nchecks = 0, nerr = 0;
    bit          mon_en = 1'b0;
    logic [31:0] last_pc = '0;
    logic [4:0]  last_wnum = '0;
    logic [31:0] next_pc = 32'hBFC01000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Records accepted earlier that are still waiting in the buffer at edge n.
    function automatic int pending(input int n);
        int c = 0;
        foreach (sb[i]) if (sb[i].due >= n) c++;
        return c;
    endfunction

    task automatic push_exp(input logic [31:0] pc, input logic [4:0] wn,
                            input logic [31:0] wd, input int n);
        int d;
        d = (n + LAT > last_due + 1) ? n + LAT : last_due + 1;
        last_due = d;
        sb.push_back('{pc, wn, wd, d});
    endtask

    // Present one cycle of retire traffic for the next edge; acc tells whether it is taken.
    task automatic drive(input bit v0, input logic [31:0] p0, input logic [4:0] w0, input logic [31:0] d0,
                         input bit v1, input logic [31:0] p1, input logic [4:0] w1, input logic [31:0] d1,
                         output bit acc);
        int n;
        bit allow;
        @(posedge clk);
        #1;
        n     = cyc + 1;
        allow = (DEPTH - pending(n)) >= 2;
        chk("allowin", 32'(allowin_o), 32'(allow));
        l0_valid_i = v0; l0_pc_i = p0; l0_wnum_i = w0; l0_wdata_i = d0;
        l1_valid_i = v1; l1_pc_i = p1; l1_wnum_i = w1; l1_wdata_i = d1;
        acc = allow;
        if (allow && v0) push_exp(p0, w0, d0, n);
        if (allow && v1) push_exp(p1, w1, d1, n);
    endtask

    task automatic idle(input int k);
        bit a;
        repeat (k) drive(0, '0, '0, '0, 0, '0, '0, '0, a);
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && sb.size() > 0; i++) idle(1);
        idle(1);
    endtask

    // Producers hold a refused record and only present a new one after acceptance.
    task automatic stream(input int ncyc, input bit dual);
        bit v0 = 0, v1 = 0, a, need = 1;
        logic [31:0] p0 = '0, p1 = '0, d0 = '0, d1 = '0;
        logic [4:0]  w0 = '0, w1 = '0;
        for (int i = 0; i < ncyc; i++) begin
            if (need) begin
                v0 = dual ? 1'b1 : 1'($urandom_range(0, 1));
                v1 = dual ? 1'b1 : 1'($urandom_range(0, 1));
                p0 = next_pc; p1 = next_pc + 4; next_pc = next_pc + 8;
                w0 = 5'($urandom_range(0, 31)); w1 = 5'($urandom_range(0, 31));
                d0 = $urandom; d1 = $urandom;
            end
            drive(v0, p0, w0, d0, v1, p1, w1, d1, a);
            need = a || !(v0 || v1);
        end
    endtask

    task automatic do_reset(input int ncyc);
        @(posedge clk);
        #1;
        rst = 1'b0; l0_valid_i = 1'b0; l1_valid_i = 1'b0;
        @(posedge clk);
        mon_en = 1'b0;
        sb.delete();
        repeat (ncyc - 1) @(posedge clk);
        #1;
        chk("rst_pc", debug_wb_pc, 32'h0);
        chk("rst_wen", 32'(debug_wb_rf_wen), 32'h0);
        chk("rst_wnum", 32'(debug_wb_rf_wnum), 32'h0);
        chk("rst_wdata", debug_wb_rf_wdata, 32'h0);
        chk("rst_allowin", 32'(allowin_o), 32'h1);
        last_due = -100; last_pc = '0; last_wnum = '0;
        rst = 1'b1;
        mon_en = 1'b1;
    endtask

    // Monitor: every cycle the trace port either shows the record due now or is idle.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                nchecks++; nerr++;
                $display("FAIL missed_record: pc %h never traced (due %0d, now %0d)", e.pc, e.due, cyc);
            end else if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk("wb_pc", debug_wb_pc, e.pc);
                chk("wb_wnum", 32'(debug_wb_rf_wnum), 32'(e.wnum));
                chk("wb_wdata", debug_wb_rf_wdata, e.wdata);
                chk("wb_wen", 32'(debug_wb_rf_wen), (e.wnum != 0) ? 32'hF : 32'h0);
                last_pc = e.pc; last_wnum = e.wnum;
            end else begin
                chk("idle_wen", 32'(debug_wb_rf_wen), 32'h0);
                chk("idle_pc_hold", debug_wb_pc, last_pc);
                chk("idle_wnum_hold", 32'(debug_wb_rf_wnum), 32'(last_wnum));
            end
        end
    end

    initial begin
        bit a;
        do_reset(2);
        // single write, then an idle cycle
        drive(1, 32'hBFC00000, 5'd3, 32'h1234, 0, '0, '0, '0, a);
        idle(3);
        // dual retire in one cycle
        drive(1, 32'hBFC00010, 5'd4, 32'hA, 1, 32'hBFC00014, 5'd5, 32'hB, a);
        idle(3);
        // record with no register write
        drive(1, 32'hBFC00020, 5'd0, 32'h55, 0, '0, '0, '0, a);
        idle(2);
        // lane1 only
        drive(0, '0, '0, '0, 1, 32'hBFC00024, 5'd7, 32'h77, a);
        idle(3);
        // sustained dual retire: buffer fills and allowin toggles
        stream(12, 1'b1);
        drain(20);
        // random traffic
        stream(40, 1'b0);
        drain(30);
        // fill until refused, then reset with records still buffered
        for (int i = 0; i < 6; i++) begin
            drive(1, next_pc, 5'd9, 32'hC0DE, 1, next_pc + 4, 5'd10, 32'hBEEF, a);
            next_pc = next_pc + 8;
            if (!a) break;
        end
        do_reset(1);
        idle(2);
        // traffic after reset starts clean
        drive(1, 32'hBFC00100, 5'd1, 32'h1, 1, 32'hBFC00104, 5'd2, 32'h2, a);
        stream(10, 1'b0);
        drain(20);
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks %0d", nchecks);
        $fatal(1);
    end

endmodule
